// File: rtl/gated_reg_bank.sv
// Multi-channel register bank with one latch-based clock gate per channel.
// Each channel adds auto-sleep, a wake handshake and a saturating gated-cycle counter.
module gated_reg_bank #(
  parameter int WIDTH       = 8,
  parameter int NCH         = 2,
  parameter int IDLE_CYCLES = 4,
  parameter int CNT_W       = 8,
  localparam int SEL_W      = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [NCH-1:0]         EN,
  input  logic [NCH*WIDTH-1:0]   D_IN,
  output logic [NCH*WIDTH-1:0]   D_OUT,
  output logic [NCH-1:0]         RDY,
  output logic [NCH-1:0]         SLEEP,
  input  logic [SEL_W-1:0]       CNT_SEL,
  input  logic                   CNT_CLR,
  output logic [CNT_W-1:0]       CNT_OUT
);

  localparam int IW        = (IDLE_CYCLES > 0) ? $clog2(IDLE_CYCLES + 1) : 1;
  localparam int IDLE_LAST = (IDLE_CYCLES > 0) ? IDLE_CYCLES - 1 : 0;

  typedef enum logic [1:0] {
    ST_AWAKE = 2'd0,
    ST_SLEEP = 2'd1,
    ST_WAKE  = 2'd2
  } state_t;

  logic [CNT_W-1:0] cnt_vec [NCH];

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    state_t           state_q, state_d;
    logic [IW-1:0]    idle_q, idle_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] data_q;
    logic             cap;
    logic             gate_en_q;
    logic             gclk;

    assign cap = EN[gi] & (state_q == ST_AWAKE);

    always_comb begin
      state_d = state_q;
      idle_d  = idle_q;
      case (state_q)
        ST_AWAKE: begin
          if (EN[gi]) begin
            idle_d = '0;
          end else if (IDLE_CYCLES > 0) begin
            if (idle_q == IW'(IDLE_LAST)) begin
              state_d = ST_SLEEP;
              idle_d  = '0;
            end else begin
              idle_d = idle_q + 1'b1;
            end
          end
        end
        ST_SLEEP: begin
          if (EN[gi]) state_d = ST_WAKE;
        end
        ST_WAKE: begin
          state_d = ST_AWAKE;
          idle_d  = '0;
        end
        default: begin
          state_d = ST_AWAKE;
          idle_d  = '0;
        end
      endcase
    end

    // Clear beats increment; saturate instead of wrapping.
    always_comb begin
      cnt_d = cnt_q;
      if (CNT_CLR) begin
        cnt_d = '0;
      end else if (!cap && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    always_ff @(posedge CLK) begin
      if (RST) begin
        state_q <= ST_AWAKE;
        idle_q  <= '0;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        idle_q  <= idle_d;
        cnt_q   <= cnt_d;
      end
    end

    // Enable latch is transparent while CLK is low, so gclk cannot glitch.
    always_latch begin
      if (!CLK) gate_en_q <= cap | RST;
    end

    assign gclk = CLK & gate_en_q;

    always_ff @(posedge gclk) begin
      if (RST) data_q <= '0;
      else     data_q <= D_IN[gi*WIDTH +: WIDTH];
    end

    assign D_OUT[gi*WIDTH +: WIDTH] = data_q;
    assign RDY[gi]                  = (state_q == ST_AWAKE);
    assign SLEEP[gi]                = (state_q == ST_SLEEP);
    assign cnt_vec[gi]              = cnt_q;
  end

  // Unmatched select values fall through to zero.
  always_comb begin
    CNT_OUT = '0;
    for (int i = 0; i < NCH; i++) begin
      if (CNT_SEL == SEL_W'(i)) CNT_OUT = cnt_vec[i];
    end
  end

endmodule

// File: tb/tb_gated_reg_bank.sv
// Directed bench for gated_reg_bank: expected values are queued as stimulus is
// driven and popped when the corresponding output is sampled.
module tb_gated_reg_bank;

  logic        clk;
  logic        rst;
  logic [1:0]  en;
  logic [15:0] d_in;
  logic [15:0] d_out;
  logic [1:0]  rdy;
  logic [1:0]  sleep;
  logic [0:0]  cnt_sel;
  logic        cnt_clr;
  logic [7:0]  cnt_out;

  logic [1:0]  en0;
  logic [15:0] d_in0;
  logic [15:0] d_out0;
  logic [1:0]  rdy0;
  logic [1:0]  sleep0;
  logic [7:0]  cnt_out0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];

  gated_reg_bank #(.WIDTH(8), .NCH(2), .IDLE_CYCLES(4), .CNT_W(8)) dut (
    .CLK(clk), .RST(rst), .EN(en), .D_IN(d_in), .D_OUT(d_out),
    .RDY(rdy), .SLEEP(sleep), .CNT_SEL(cnt_sel), .CNT_CLR(cnt_clr),
    .CNT_OUT(cnt_out)
  );

  gated_reg_bank #(.WIDTH(8), .NCH(2), .IDLE_CYCLES(0), .CNT_W(8)) dut0 (
    .CLK(clk), .RST(rst), .EN(en0), .D_IN(d_in0), .D_OUT(d_out0),
    .RDY(rdy0), .SLEEP(sleep0), .CNT_SEL(1'b0), .CNT_CLR(1'b0),
    .CNT_OUT(cnt_out0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty observed=%0h", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
      end
    end
  endtask

  initial begin
    rst = 1'b1; en = 2'b00; d_in = 16'h0000; cnt_sel = 1'b0; cnt_clr = 1'b0;
    en0 = 2'b00; d_in0 = 16'h0000;

    // Reset state
    push("rst_dout", 32'h0000); push("rst_rdy", 32'h3);
    push("rst_sleep", 32'h0); push("rst_cnt", 32'h0);
    step(1);
    check(32'(d_out)); check(32'(rdy)); check(32'(sleep)); check(32'(cnt_out));
    rst = 1'b0;

    // 1: single capture on ch0
    en = 2'b01; d_in = 16'h0004;
    push("t1_dout", 32'h0004); push("t1_rdy", 32'h3);
    step(1);
    check(32'(d_out)); check(32'(rdy));

    // 2: idle; ch1 has one idle edge already, so it sleeps one edge earlier
    en = 2'b00; d_in = 16'h00FF;
    step(2);
    push("t2_sleep_e3", 32'h2); push("t2_rdy_e3", 32'h1);
    step(1);
    check(32'(sleep)); check(32'(rdy));
    push("t2_sleep_e4", 32'h3); push("t2_rdy_e4", 32'h0); push("t2_dout_held", 32'h0004);
    step(1);
    check(32'(sleep)); check(32'(rdy)); check(32'(d_out));

    // 3: wake handshake on ch0
    en = 2'b01; d_in = 16'h000D;
    push("t3_sleep_e1", 32'h2); push("t3_rdy_e1", 32'h0);
    step(1);
    check(32'(sleep)); check(32'(rdy));
    push("t3_rdy_e2", 32'h1); push("t3_dout_e2", 32'h0004);
    step(1);
    check(32'(rdy)); check(32'(d_out));
    push("t3_dout_e3", 32'h000D); push("t3_cnt0", 32'd6);
    step(1);
    check(32'(d_out)); check(32'(cnt_out));

    // 5: back to sleep, then reset mid-sleep
    en = 2'b00;
    push("t5_sleep_pre", 32'h3);
    step(4);
    check(32'(sleep));
    rst = 1'b1;
    push("t5_dout", 32'h0000); push("t5_sleep", 32'h0);
    push("t5_rdy", 32'h3); push("t5_cnt", 32'h0);
    step(1);
    check(32'(d_out)); check(32'(sleep)); check(32'(rdy)); check(32'(cnt_out));
    rst = 1'b0;

    // 4: ch1 gated-cycle counter, clear and saturation
    cnt_sel = 1'b1;
    push("t4_cnt10", 32'd10);
    step(10);
    check(32'(cnt_out));
    cnt_clr = 1'b1;
    push("t4_clr", 32'd0);
    step(1);
    check(32'(cnt_out));
    cnt_clr = 1'b0;
    push("t4_cnt254", 32'd254);
    step(254);
    check(32'(cnt_out));
    push("t4_sat", 32'd255);
    step(46);
    check(32'(cnt_out));

    // 6: auto-sleep disabled instance
    push("t6_sleep", 32'h0); push("t6_rdy", 32'h3);
    step(100);
    check(32'(sleep0)); check(32'(rdy0));
    en0 = 2'b01; d_in0 = 16'h00FE;
    push("t6_dout", 32'h00FE);
    step(1);
    check(32'(d_out0));
    en0 = 2'b00; d_in0 = 16'h0011;
    push("t6_hold", 32'h00FE);
    step(1);
    check(32'(d_out0));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
